// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - framebuffer single-port RAM arbiter: scanout reads over two round-robin draw writers
//
// Purpose: shares one synchronous single-port framebuffer RAM between the
// display scanout (strict priority) and two draw-writer channels that are
// served round-robin. The grant is decided combinationally in cycle N and the
// memory access is launched from registers in cycle N+1. Read data returns
// one cycle later and is passed straight through to the scanout.
//
// Optional feature: define FB_ARBITER_VBLANK_WRITE_EN to let writers in only
// while vblank=1 (tear-free drawing). Without it vblank is ignored.
//
// Ports:
//   clk, reset            system clock; asynchronous active-high reset
//   disp_req, disp_addr   scanout read request pulse and word address
//   disp_rvalid, disp_rdata  scanout read data strobe (N+2) and data
//   wr0_*/wr1_*           writer channels: req/addr/data held until ack
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata  RAM port (1-cycle read)
//   vblank                vertical blank from the timing generator
//   stall_clr, stall_cnt  writer stall counter (saturating) and its clear
module fb_arbiter #(
   parameter int AW = 17,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_rvalid,
   output logic [DW-1:0] disp_rdata,
   input  logic          wr0_req,
   input  logic [AW-1:0] wr0_addr,
   input  logic [DW-1:0] wr0_data,
   output logic          wr0_ack,
   input  logic          wr1_req,
   input  logic [AW-1:0] wr1_addr,
   input  logic [DW-1:0] wr1_data,
   output logic          wr1_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          vblank,
   input  logic          stall_clr,
   output logic [15:0]   stall_cnt
);

   logic write_gate;
   logic elig0, elig1;
   logic grant_rd, grant_w0, grant_w1;
   logic stall_inc;
   // Round-robin pointer: 1 means wr1 wins the next two-way contest.
   logic favor_wr1;

`ifdef FB_ARBITER_VBLANK_WRITE_EN
   assign write_gate = vblank;
`else
   // vblank is ignored in this build; writers may go whenever display is idle.
   assign write_gate = vblank | 1'b1;
`endif

   always_comb begin
      // A writer whose ack is showing this cycle has just completed; a still
      // high req is a new transaction and competes from the next cycle on.
      elig0    = wr0_req & ~wr0_ack;
      elig1    = wr1_req & ~wr1_ack;
      grant_rd = disp_req;
      grant_w0 = 1'b0;
      grant_w1 = 1'b0;
      if (!disp_req && write_gate) begin
         if (elig0 && (!elig1 || !favor_wr1)) begin
            grant_w0 = 1'b1;
         end else if (elig1) begin
            grant_w1 = 1'b1;
         end
      end
      stall_inc = (elig0 | elig1) & ~(grant_w0 | grant_w1);
   end

   // Read data is not registered: the RAM already supplies it in N+2.
   assign disp_rdata = mem_rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         wr0_ack     <= 1'b0;
         wr1_ack     <= 1'b0;
         disp_rvalid <= 1'b0;
         favor_wr1   <= 1'b0;
         stall_cnt   <= 16'd0;
      end else begin
         mem_en      <= grant_rd | grant_w0 | grant_w1;
         mem_we      <= grant_w0 | grant_w1;
         wr0_ack     <= grant_w0;
         wr1_ack     <= grant_w1;
         disp_rvalid <= mem_en & ~mem_we;

         // Address/data hold their last values on idle cycles.
         if (grant_rd) begin
            mem_addr <= disp_addr;
         end else if (grant_w0) begin
            mem_addr  <= wr0_addr;
            mem_wdata <= wr0_data;
         end else if (grant_w1) begin
            mem_addr  <= wr1_addr;
            mem_wdata <= wr1_data;
         end

         if (grant_w0) begin
            favor_wr1 <= 1'b1;
         end else if (grant_w1) begin
            favor_wr1 <= 1'b0;
         end

         if (stall_clr) begin
            stall_cnt <= 16'd0;
         end else if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 17, framebuffer word-address width.
REQ-002 SHALL have parameter DW, default 12, pixel width (RGB 4:4:4).
REQ-003 SHALL have port clk input 1, system clock.
REQ-004 SHALL have port reset input 1, asynchronous, active-high.
REQ-005 SHALL have ports disp_req input 1, disp_addr input AW: scanout read request (single-cycle pulse) and address.
REQ-006 SHALL have ports disp_rvalid output 1, disp_rdata output DW: scanout read data and its valid strobe.
REQ-007 SHALL have ports wrN_req input 1, wrN_addr input AW, wrN_data input DW, wrN_ack output 1, for N = 0 and 1: draw-writer channels.
REQ-008 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output AW, mem_wdata output DW, mem_rdata input DW: single-port synchronous RAM, 1-cycle read latency.
REQ-009 SHALL have port vblank input 1, vertical-blank indication from the timing generator.
REQ-010 SHALL have ports stall_clr input 1, stall_cnt output 16: writer stall statistics.

Function
REQ-011 SHALL grant at most one requester per cycle; the grant is decided in cycle N and the memory access is issued from registers in cycle N+1.
REQ-012 SHALL give display strict priority: disp_req=1 in cycle N always yields mem_en=1, mem_we=0, mem_addr=disp_addr(N) in N+1.
REQ-013 SHALL assert disp_rvalid=1 in N+2 with disp_rdata=mem_rdata (pass-through); disp_rvalid is 0 in all other cycles.
REQ-014 SHALL treat writer N as eligible in a cycle when wrN_req=1 and wrN_ack=0 in that cycle.
REQ-015 SHALL grant an eligible writer only when disp_req=0 (and the write gate of REQ-026 is open).
REQ-016 SHALL, on a writer grant in cycle N, drive mem_en=1, mem_we=1, mem_addr=wrN_addr(N), mem_wdata=wrN_data(N) and wrN_ack=1 for exactly cycle N+1.
REQ-017 SHALL require writers to hold req/addr/data stable until ack; a writer still requesting after its ack cycle starts a new transaction.
REQ-018 SHALL arbitrate between both eligible writers round-robin using a last-grant pointer, updated only on a writer grant; the pointer favours wr0 after reset.
REQ-019 SHALL grant a sole eligible writer regardless of the pointer; back-to-back writes from one writer therefore occur at most every 2 cycles.
REQ-020 SHALL drive mem_en=0, mem_we=0 and both acks 0 in N+1 when nothing is granted in N; mem_addr and mem_wdata hold their last values.
REQ-021 SHALL increment stall_cnt in every cycle in which at least one writer is eligible but no writer is granted, saturating at 65535.
REQ-022 SHALL clear stall_cnt to 0 on stall_clr=1 in the following cycle; clear has priority over increment.

Reset
REQ-023 SHALL on reset force mem_en, mem_we, mem_addr, mem_wdata, wrN_ack, disp_rvalid and stall_cnt to 0, and the RR pointer to favour wr0, immediately and asynchronously.
REQ-024 SHALL drop any in-flight grant on reset mid-operation: no ack and no memory write is issued for it; a writer still requesting after reset release is re-arbitrated normally.
REQ-025 SHALL resume arbitration on the first clk edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro FB_ARBITER_VBLANK_WRITE_EN defined, grant writers only in cycles with vblank=1 (tear-free drawing); stall cycles of REQ-021 include vblank=0 waits. Without the macro, vblank is ignored and writers are granted whenever disp_req=0.

Verification
REQ-027 SHALL test: disp_req pulse with disp_addr=0x00123 and mem_rdata=0xABC one cycle after mem_en -> mem_en=1, mem_we=0, addr 0x00123 at N+1; disp_rvalid=1 with disp_rdata=0xABC at N+2.
REQ-028 SHALL test: wr0_req held with addr 0x00010 / data 0xF00, plus disp_req in the same cycle N -> read at N+1, write at N+2 with wr0_ack=1 only at N+2, stall_cnt=1.
REQ-029 SHALL test: wr0 and wr1 both held requesting for 8 cycles, no display traffic -> acks alternate wr0, wr1, wr0, wr1, starting with wr0 after reset.
REQ-030 SHALL test: reset asserted in the cycle after a wr1 grant decision -> no wr1_ack and no mem_we; after release with wr1_req still high, wr1 is acked exactly once.
REQ-031 SHALL test: stall condition forced for 70000 cycles -> stall_cnt=65535; stall_clr pulse -> stall_cnt=0 in the next cycle.
REQ-032 SHALL test, with FB_ARBITER_VBLANK_WRITE_EN defined: wr0_req held with vblank=0 for 5 cycles, then vblank=1 -> no ack for those 5 cycles, ack follows 1 cycle after vblank rises, stall_cnt=5.
